// File: rtl/sequential_subtractor.sv
// sequential_subtractor
//   Multi-cycle WIDTH-bit subtractor computing res = a - b one CHUNK-bit slice per cycle,
//   LSB slice first, as a + ~b + 1 with the borrow chain held in a 1-bit carry register.
//   Shares the start/ready handshake of the byte-serial adder.
//
// Ports
//   clk       in   1      clock, all state updates on posedge
//   rst       in   1      synchronous active-low reset
//   a         in   WIDTH  minuend, sampled when start is accepted
//   b         in   WIDTH  subtrahend, sampled when start is accepted
//   start     in   1      request, accepted only in idle
//   res       out  WIDTH  difference, valid while ready is high
//   borrow    out  1      unsigned underflow (a < b)
//   overflow  out  1      signed two's-complement overflow
//   ready     out  1      one-cycle pulse when res/borrow/overflow are valid
//
// WIDTH must be a multiple of CHUNK.
module sequential_subtractor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  output logic [WIDTH-1:0] res,
  output logic             borrow,
  output logic             overflow,
  output logic             ready
);

  localparam int unsigned NSLICE = WIDTH / CHUNK;
  // Keep the counter at least 1 bit wide so NSLICE == 1 still elaborates.
  localparam int unsigned CntW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  res_q;
  logic              borrow_q;
  logic              overflow_q;

  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [CHUNK:0]    sum;

  // One slice of a + ~b + carry; sum[CHUNK] is the carry out (borrow = ~carry).
  always_comb begin
    a_sl = a_q[cnt_q*CHUNK +: CHUNK];
    b_sl = b_q[cnt_q*CHUNK +: CHUNK];
    sum  = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      borrow_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            carry_q <= 1'b1;
            state_q <= StSub;
          end
        end
        StSub: begin
          res_q[cnt_q*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
          carry_q                     <= sum[CHUNK];
          cnt_q                       <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q    <= StDone;
            borrow_q   <= ~sum[CHUNK];
            // Signed overflow: operand signs differ and result sign differs from a.
            overflow_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign res      = res_q;
  assign borrow   = borrow_q;
  assign overflow = overflow_q;
  assign ready    = (state_q == StDone);

endmodule

// File: tb/tb_sequential_subtractor.sv
module tb_sequential_subtractor;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NSLICE = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             bo;
    logic             ov;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic             overflow;
  logic             ready;

  exp_t sb[$];
  int   vecs = 0;
  int   errs = 0;

  sequential_subtractor #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .start   (start),
    .res     (res),
    .borrow  (borrow),
    .overflow(overflow),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vecs++;
    assert (obs === exp_v)
    else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drives one operation from a negedge, waits (bounded) for ready, checks result and pulse width.
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input bit junk, input bit chk_carry);
    exp_t              e;
    exp_t              got;
    logic [WIDTH:0]    d;
    logic [CHUNK:0]    s;
    logic              c;
    logic [NSLICE-1:0] carries;
    int                lat;
    d    = {1'b0, ta} - {1'b0, tb_v};
    e.res = d[WIDTH-1:0];
    e.bo  = d[WIDTH];
    e.ov  = (ta[WIDTH-1] != tb_v[WIDTH-1]) && (d[WIDTH-1] != ta[WIDTH-1]);
    c = 1'b1;
    for (int k = 0; k < int'(NSLICE); k++) begin
      s = {1'b0, ta[k*CHUNK +: CHUNK]} + {1'b0, ~tb_v[k*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
      c = s[CHUNK];
      carries[k] = c;
    end
    sb.push_back(e);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (chk_carry && i >= 2 && i <= int'(NSLICE) + 1)
        chk($sformatf("carry_slice%0d", i - 2), {63'd0, dut.carry_q}, {63'd0, carries[i-2]});
      if (ready) begin
        lat = i;
        break;
      end
      if (junk) begin
        a = $urandom;
        b = $urandom;
        start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(NSLICE + 1));
    got = sb.pop_front();
    if (lat != 0) begin
      chk("res", {32'd0, res}, {32'd0, got.res});
      chk("borrow", {63'd0, borrow}, {63'd0, got.bo});
      chk("overflow", {63'd0, overflow}, {63'd0, got.ov});
      @(negedge clk);
      chk("ready_one_pulse", {63'd0, ready}, 64'd0);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset_res", {32'd0, res}, 64'd0);
    chk("reset_borrow", {63'd0, borrow}, 64'd0);
    chk("reset_overflow", {63'd0, overflow}, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(32'h0100_0000, 32'h0000_0001, 1'b0, 1'b1);
    run_op(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1);
    run_op(32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0);
    // Starts and operand changes while busy must be ignored.
    run_op(32'h1234_5678, 32'h0765_4321, 1'b1, 1'b0);
    run_op(32'h0000_0010, 32'h8000_0000, 1'b1, 1'b0);

    // Reset in the middle of an operation.
    a = 32'h1234_5678;
    b = 32'h0000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_res", {32'd0, res}, 64'd0);
    chk("midrst_borrow", {63'd0, borrow}, 64'd0);
    chk("midrst_overflow", {63'd0, overflow}, 64'd0);
    chk("midrst_ready", {63'd0, ready}, 64'd0);
    chk("midrst_state", {62'd0, dut.state_q}, 64'd0);
    chk("midrst_a_q", {32'd0, dut.a_q}, 64'd0);
    rst = 1'b1;
    for (int i = 0; i < int'(NSLICE) + 2; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", {63'd0, ready}, 64'd0);
    end
    run_op(32'h0000_0100, 32'h0000_0101, 1'b0, 1'b1);

    // Random operands against a 33-bit reference.
    for (int n = 0; n < 10000; n++) begin
      run_op($urandom, $urandom, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
